// File: rtl/processor_pkg.sv
// -----------------------------------------------------------------------------
// processor_pkg
//   Shared definitions for the instruction fetch front end.
//   - Default address / instruction widths.
//   - Fetch FSM state type (IDLE / FETCH / DRAIN, 2-bit encoding).
//   - Fetch queue entry {pc, inst} and queue sizing constants.
// -----------------------------------------------------------------------------
package processor_pkg;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int INST_W_DEFAULT = 16;

  // Fetch queue depth, and the same value in the width of the occupancy count.
  localparam int QUEUE_DEPTH = 2;
  typedef logic [1:0] count_t;
  localparam count_t QUEUE_FULL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,  // no request outstanding
    FETCH = 2'b01,  // request outstanding, response will be buffered
    DRAIN = 2'b10   // request outstanding, response will be discarded
  } fetch_state_e;

  // The entry widths follow the package defaults; the top-level width
  // parameters are expected to stay at these values.
  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] pc;
    logic [INST_W_DEFAULT-1:0] inst;
  } queue_entry_t;

endpackage : processor_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Two-entry FIFO holding fetched {pc, inst} pairs between instruction memory
//   and the decoder. Flush has priority over push and pop in the same cycle.
//
// Ports:
//   p2            clock, all state updates on posedge
//   reset         asynchronous active-low reset
//   push_i        write push_entry_i at the tail
//   push_entry_i  entry to write
//   pop_i         remove the head (ignored while empty)
//   flush_i       empty the queue
//   count_o       current occupancy (0..2)
//   head_o        entry at the head of the queue
// -----------------------------------------------------------------------------
module fetch_queue
  import processor_pkg::*;
(
  input  logic         p2,
  input  logic         reset,
  input  logic         push_i,
  input  queue_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output count_t       count_o,
  output queue_entry_t head_o
);

  queue_entry_t slot_q [QUEUE_DEPTH];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  count_t       count_q;
  count_t       count_d;
  logic         pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign count_d = count_q + count_t'(push_i) - count_t'(pop_ok);

  always_ff @(posedge p2 or negedge reset) begin
    if (!reset) begin
      // NOTE: the two storage slots are reset as well, so the head output
      // reads zero after reset instead of X; at this depth it costs nothing.
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= '0;
    end else if (flush_i) begin
      // Stored words are left in place; only the pointers and count matter.
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks, so every register
      // samples the pre-edge values regardless of statement order.
      if (push_i) begin
        slot_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = slot_q[rd_ptr_q];

endmodule : fetch_queue

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Processor front end: generates word addresses, performs a single
//   outstanding request/ack handshake with instruction memory, buffers fetched
//   words in a 2-entry queue and hands them to the decoder via valid/ready.
//   Branch redirects flush the queue and discard an in-flight response; halt
//   stops new requests while queued words still drain.
//
// Ports:
//   p2 / reset          clock / asynchronous active-low reset
//   mem_req, mem_addr   fetch request and address (held until mem_ack)
//   mem_ack, mem_rdata  memory acceptance and returned word
//   inst_to_decoder     head-of-queue instruction
//   inst_pc             address of inst_to_decoder
//   inst_valid          queue non-empty
//   inst_ready          consumer takes the head this cycle
//   branch_valid        single-cycle redirect request
//   branch_target       redirect address
//   halt                level, suppresses new requests
//   fetch_count         (FETCH_STATS_EN only) buffered-fetch counter
//   flush_count         (FETCH_STATS_EN only) redirect counter
//
// Build option: define FETCH_STATS_EN to add the two 16-bit statistics
// counters and their output ports.
// -----------------------------------------------------------------------------
module inst_fetch_unit
  import processor_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter int                INST_W   = INST_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              p2,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [INST_W-1:0] inst_to_decoder,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] pc_inc;

  logic              push;
  logic              pop;
  logic              flush;
  count_t            count;
  count_t            count_after_pop;
  logic              room_idle;
  logic              room_fetch;
  queue_entry_t      push_entry;
  queue_entry_t      head;

  // ---------------------------------------------------------------------------
  // Queue occupancy helpers
  // ---------------------------------------------------------------------------
  assign pop             = inst_valid && inst_ready;
  assign count_after_pop = count - count_t'(pop);
  // Room for a new request counts this cycle's pop; in FETCH the word being
  // acked this cycle also occupies a slot, so one more push must still fit.
  assign room_idle       = count_after_pop < QUEUE_FULL;
  assign room_fetch      = (count_after_pop + count_t'(1)) < QUEUE_FULL;
  // Natural modulo arithmetic wraps 16'hFFFF to 16'h0000.
  assign pc_inc          = pc_q + ADDR_W'(1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge p2 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address registers updated alongside the state.
  always_ff @(posedge p2 or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (branch_valid) begin
          flush = 1'b1;
          pc_d  = branch_target;
        end else if (!halt && room_idle) begin
          state_d    = FETCH;
          mem_addr_d = pc_q;
        end
      end

      FETCH: begin
        if (branch_valid) begin
          flush = 1'b1;
          pc_d  = branch_target;
          if (mem_ack) begin
            // The acked word is dropped; restart directly at the target.
            state_d    = halt ? IDLE : FETCH;
            mem_addr_d = branch_target;
          end else begin
            // Request must still complete with its original address.
            state_d = DRAIN;
          end
        end else if (mem_ack) begin
          push = 1'b1;
          pc_d = pc_inc;
          if (!halt && room_fetch) begin
            mem_addr_d = pc_inc;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DRAIN: begin
        if (branch_valid) begin
          flush = 1'b1;
          pc_d  = branch_target;
        end
        if (mem_ack) begin
          // Queue is empty after the flush, so room is guaranteed.
          state_d    = halt ? IDLE : FETCH;
          mem_addr_d = pc_d;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req = 1'b0;
    unique case (state_q)
      FETCH, DRAIN: mem_req = 1'b1;
      default:      mem_req = 1'b0;
    endcase
  end

  assign mem_addr = mem_addr_q;

  // ---------------------------------------------------------------------------
  // Fetch queue
  // ---------------------------------------------------------------------------
  assign push_entry = '{pc: mem_addr_q, inst: mem_rdata};

  fetch_queue u_fetch_queue (
    .p2           (p2),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (flush),
    .count_o      (count),
    .head_o       (head)
  );

  assign inst_valid      = (count != '0);
  assign inst_to_decoder = head.inst;
  assign inst_pc         = head.pc;

`ifdef FETCH_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics: buffered fetches and redirects, both free-running and wrapping
  // ---------------------------------------------------------------------------
  logic [15:0] fetch_count_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge p2 or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (push) begin
        fetch_count_q <= fetch_count_q + 16'd1;
      end
      if (branch_valid) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule : inst_fetch_unit

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Directed scenarios followed by a randomized run. Memory returns a fixed
//   function of the address, so every delivered word can be checked against
//   the program-order address sequence the consumer should observe.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  logic        p2;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] inst_to_decoder;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        halt;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;

  inst_fetch_unit #(
    .ADDR_W   (16),
    .INST_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .p2              (p2),
    .reset           (reset),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .inst_to_decoder (inst_to_decoder),
    .inst_pc         (inst_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .branch_valid    (branch_valid),
    .branch_target   (branch_target),
    .halt            (halt)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count     (fetch_count),
    .flush_count     (flush_count)
`endif
  );

  initial p2 = 1'b0;
  always #5 p2 = ~p2;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge, and
  // memory presents the word for the address currently on the bus.
  task automatic tick();
    @(posedge p2);
    #1;
    mem_rdata = mem_fn(mem_addr);
  endtask

  // Reference-model state for the randomized run.
  logic [15:0] exp_pc;
  int          delivered;
  logic        prev_req, prev_ack, prev_halt, prev_branch;
  logic [15:0] prev_addr;

  initial begin
    reset         = 1'b0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    inst_ready    = 1'b0;
    branch_valid  = 1'b0;
    branch_target = '0;
    halt          = 1'b0;

    // ---- Reset values --------------------------------------------------------
    tick();
    tick();
    check("rst_mem_req",  mem_req,         32'd0);
    check("rst_mem_addr", mem_addr,        32'h0000);
    check("rst_valid",    inst_valid,      32'd0);
    check("rst_inst",     inst_to_decoder, 32'h0000);
    check("rst_inst_pc",  inst_pc,         32'h0000);

    // ---- Streaming with zero-wait memory ------------------------------------
    mem_ack    = 1'b1;
    inst_ready = 1'b1;
    reset      = 1'b1;
    tick();
    check("s1_req",   mem_req,    32'd1);
    check("s1_addr0", mem_addr,   32'h0000);
    check("s1_valid", inst_valid, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("s1_addr",  mem_addr,        32'(i));
      check("s1_valid", inst_valid,      32'd1);
      check("s1_pc",    inst_pc,         32'(i - 1));
      check("s1_inst",  inst_to_decoder, 32'(mem_fn(16'(i - 1))));
    end

    // ---- Asynchronous reset mid-fetch ---------------------------------------
    reset = 1'b0;
    #1;
    check("async_rst_req",   mem_req,    32'd0);
    check("async_rst_valid", inst_valid, 32'd0);
    inst_ready = 1'b0;
    tick();
    reset = 1'b1;

    // ---- Consumer stalled: queue fills, requests stop -----------------------
    tick();
    check("s2_first_addr", mem_addr, 32'h0000);
    tick();
    check("s2_addr1", mem_addr, 32'h0001);
    tick();
    check("s2_full_req",   mem_req,    32'd0);
    check("s2_full_valid", inst_valid, 32'd1);
    check("s2_full_pc",    inst_pc,    32'h0000);
    tick();
    check("s2_stall_req", mem_req, 32'd0);
    check("s2_stall_pc",  inst_pc, 32'h0000);
    inst_ready = 1'b1;
    tick();
    check("s2_resume_req",  mem_req,  32'd1);
    check("s2_resume_addr", mem_addr, 32'h0002);
    check("s2_resume_pc",   inst_pc,  32'h0001);
    tick();
    check("s2_next_addr", mem_addr, 32'h0003);
    check("s2_next_pc",   inst_pc,  32'h0002);

    // ---- Redirect while a request waits for a delayed ack -------------------
    reset   = 1'b0;
    mem_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("s3_req",  mem_req,  32'd1);
    check("s3_addr", mem_addr, 32'h0000);
    branch_valid  = 1'b1;
    branch_target = 16'h0040;
    tick();
    branch_valid = 1'b0;
    check("s3_hold_req",   mem_req,    32'd1);
    check("s3_hold_addr",  mem_addr,   32'h0000);
    check("s3_hold_valid", inst_valid, 32'd0);
    tick();
    check("s3_hold_addr2", mem_addr, 32'h0000);
    tick();
    check("s3_hold_addr3", mem_addr, 32'h0000);
    mem_ack = 1'b1;
    tick();
    check("s3_target_addr",  mem_addr,   32'h0040);
    check("s3_discard",      inst_valid, 32'd0);
    tick();
    check("s3_first_valid", inst_valid,      32'd1);
    check("s3_first_pc",    inst_pc,         32'h0040);
    check("s3_first_inst",  inst_to_decoder, 32'(mem_fn(16'h0040)));
    check("s3_next_addr",   mem_addr,        32'h0041);

    // ---- Redirect in the same cycle as an ack --------------------------------
    branch_valid  = 1'b1;
    branch_target = 16'h0100;
    tick();
    branch_valid = 1'b0;
    check("s4_addr",  mem_addr,   32'h0100);
    check("s4_flush", inst_valid, 32'd0);
    tick();
    check("s4_pc",   inst_pc,  32'h0100);
    check("s4_addr2", mem_addr, 32'h0101);

    // ---- Address wrap -------------------------------------------------------
    branch_valid  = 1'b1;
    branch_target = 16'hFFFF;
    tick();
    branch_valid = 1'b0;
    check("s5_addr_ffff", mem_addr, 32'hFFFF);
    tick();
    check("s5_addr_wrap", mem_addr,        32'h0000);
    check("s5_pc_ffff",   inst_pc,         32'hFFFF);
    check("s5_inst_ffff", inst_to_decoder, 32'(mem_fn(16'hFFFF)));
    tick();
    check("s5_addr1",  mem_addr, 32'h0001);
    check("s5_pc_wrap", inst_pc, 32'h0000);

    // ---- Halt during an outstanding fetch -----------------------------------
    mem_ack = 1'b0;
    tick();
    check("s6_req",   mem_req,    32'd1);
    check("s6_addr",  mem_addr,   32'h0001);
    check("s6_empty", inst_valid, 32'd0);
    halt = 1'b1;
    tick();
    check("s6_outstanding", mem_req, 32'd1);
    mem_ack = 1'b1;
    tick();
    check("s6_halt_req",  mem_req,         32'd0);
    check("s6_halt_valid", inst_valid,     32'd1);
    check("s6_halt_pc",   inst_pc,         32'h0001);
    check("s6_halt_inst", inst_to_decoder, 32'(mem_fn(16'h0001)));
    tick();
    check("s6_drained", inst_valid, 32'd0);
    tick();
    tick();
    check("s6_halt_idle", mem_req, 32'd0);
    halt = 1'b0;
    tick();
    check("s6_unhalt_req",  mem_req,  32'd1);
    check("s6_unhalt_addr", mem_addr, 32'h0002);

    // ---- Randomized run against the program-order model ---------------------
    reset        = 1'b0;
    mem_ack      = 1'b0;
    halt         = 1'b0;
    branch_valid = 1'b0;
    tick();
    reset       = 1'b1;
    exp_pc      = 16'h0000;
    delivered   = 0;
    prev_req    = 1'b0;
    prev_ack    = 1'b0;
    prev_halt   = 1'b0;
    prev_branch = 1'b0;
    prev_addr   = 16'h0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      // A waiting request keeps its address until acked.
      if (prev_req && !prev_ack) begin
        check("rnd_req_hold",  mem_req,  32'd1);
        check("rnd_addr_hold", mem_addr, 32'(prev_addr));
      end
      // No request may start while halted.
      if (prev_halt && !prev_req) begin
        check("rnd_halt_idle", mem_req, 32'd0);
      end
      // A redirect leaves nothing deliverable in the following cycle.
      if (prev_branch) begin
        check("rnd_flush", inst_valid, 32'd0);
      end

      mem_ack       = ($urandom_range(0, 2) != 0);
      inst_ready    = ($urandom_range(0, 3) != 0);
      halt          = ($urandom_range(0, 9) == 0);
      branch_valid  = ($urandom_range(0, 24) == 0);
      branch_target = 16'($urandom);

      // Delivered words follow program order from the last redirect target.
      if (inst_valid && inst_ready) begin
        check("rnd_pc",   inst_pc,         32'(exp_pc));
        check("rnd_inst", inst_to_decoder, 32'(mem_fn(exp_pc)));
        exp_pc    = exp_pc + 16'd1;
        delivered = delivered + 1;
      end
      if (branch_valid) begin
        exp_pc = branch_target;
      end

      prev_req    = mem_req;
      prev_ack    = mem_ack;
      prev_halt   = halt;
      prev_branch = branch_valid;
      prev_addr   = mem_addr;
    end
    check("rnd_progress", 32'(delivered > 500), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_inst_fetch_unit

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Front end of the processor. Generates instruction addresses, handshakes with instruction memory, and buffers fetched words in a 2-entry queue.
- Delivers instructions to the instruction-register/decoder side using a valid/ready handshake.
- Handles branch redirects, including flushing the queue and discarding in-flight fetches, and halt.

Parameters:
- ADDR_W, 16, instruction address width (word addressed)
- INST_W, 16, instruction word width
- RESET_PC, 16'h0000, first fetch address after reset

Ports:
- p2  in  1  clock; all state updates on posedge p2
- reset  in  1  asynchronous, active-low reset (reset == 1'b0 clears all state immediately)
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  ADDR_W  fetch address; stable while mem_req=1 and no mem_ack
- mem_ack  in  1  memory accepted request and mem_rdata is valid this cycle
- mem_rdata  in  INST_W  fetched instruction word
- inst_to_decoder  out  INST_W  head-of-queue instruction
- inst_pc  out  ADDR_W  address of inst_to_decoder
- inst_valid  out  1  queue non-empty
- inst_ready  in  1  consumer accepts head this cycle
- branch_valid  in  1  redirect request, single-cycle pulse
- branch_target  in  ADDR_W  redirect address
- halt  in  1  level; suppresses new requests

Behaviour:
- Reset values:
  - pc=RESET_PC, state=IDLE, queue empty.
  - mem_req=0, mem_addr=RESET_PC.
  - inst_to_decoder=0, inst_pc=0, inst_valid=0.
- FSM states: IDLE, FETCH, DRAIN.
  - At most one request is outstanding.
  - mem_req=1 in FETCH and DRAIN.
  - mem_addr is registered and held until mem_ack.
- IDLE → FETCH when !halt and the queue has room.
  - Room means count_next<2, where count_next includes this cycle's pop.
  - In this transition mem_addr is loaded with pc.
- In FETCH, when mem_ack=1:
  - {mem_rdata, mem_addr} is pushed into the queue.
  - pc <= pc+1, wrapping 16'hFFFF → 16'h0000.
  - If !halt and there is still room after the push and pop, stay in FETCH with mem_addr=pc+1 (back-to-back, no bubble).
  - Otherwise go to IDLE.
- In FETCH, when mem_ack=0: hold state.
- Redirect (branch_valid=1) has priority over everything else:
  - The queue is flushed and pc <= branch_target.
  - In FETCH with no mem_ack that cycle: go to DRAIN. The old mem_addr and mem_req are held until ack, and the ack data is discarded. Then go to FETCH at the target (or IDLE if halt).
  - In FETCH with mem_ack the same cycle: the ack data is discarded. Next state is FETCH with mem_addr=branch_target (IDLE if halt).
  - In IDLE: pc is updated; the normal IDLE rule applies next cycle.
  - In DRAIN: pc is updated to the newest target and the drain continues.
  - A pop and a flush in the same cycle: the flush wins. The consumer's handshake completes, but no data is meaningful afterwards.
- Queue behaviour:
  - inst_valid = count != 0.
  - The head is popped when inst_valid && inst_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - The queue never overflows: a request is issued only when room exists.
- Halt:
  - An outstanding request always completes and is buffered (unless flushed).
  - No new request is issued while halt=1.
  - Queued data still drains to the consumer.
- Latency: the first instruction is valid 2 cycles after the IDLE → FETCH decision when memory acks immediately. Steady-state throughput is 1 instruction/cycle with zero-wait memory.
- Reset mid-operation: all state clears asynchronously. Any memory ack arriving after reset release while in IDLE is ignored.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined, adds output fetch_count (16 bits) and output flush_count (16 bits).
  - fetch_count increments on every accepted, non-discarded push.
  - flush_count increments on every branch_valid.
  - Both wrap at 16'hFFFF, reset to 0, and are counted even while halted.
- When not defined, neither port nor any counter logic exists.

Decomposition:
- Shared package processor_pkg holds:
  - ADDR_W/INST_W defaults
  - the FSM state type (IDLE/FETCH/DRAIN, 2-bit encoding)
  - the queue entry struct {pc, inst}
- Sub-module fetch_queue: a 2-entry FIFO with push, pop, flush, count, and head outputs. Clocked on p2 with async active-low reset.

Test Plan:
- Reset release, halt=0, mem_ack tied 1, inst_ready=1 → mem_addr sequence 0,1,2,3. inst_to_decoder follows mem_rdata with inst_pc 0,1,2 and no bubbles.
- inst_ready=0 with zero-wait memory → exactly 2 entries queued, mem_req drops, inst_valid stays 1. Raising inst_ready resumes fetching at pc=2.
- Redirect with branch_target=16'h0040 while in FETCH and mem_ack delayed 3 cycles → mem_addr held at the old value until ack, ack data discarded. Next request at 16'h0040 and the first delivered inst_pc=16'h0040.
- Redirect in the same cycle as mem_ack → that word is never delivered. Next mem_addr equals branch_target.
- Sequential fetch from pc=16'hFFFF → the next mem_addr is 16'h0000.
- halt=1 asserted during an outstanding fetch → that word is delivered, mem_req stays 0 afterwards. Asserting reset=0 mid-fetch clears inst_valid and mem_req immediately; after release the first address is RESET_PC.
